// File: rtl/serial_out.sv
// serial_out: shifts a packed row of up to MAX_FEATURES+1 words out on a single
// serial line. Each word goes out MSB first, framed by a start bit (1) and a
// stop bit (0). Words go out back to back with no idle gap between frames.
//
// Ports:
//   CLK    rising-edge clock
//   RST    synchronous active-low reset
//   start  transmit request, only honoured while idle
//   feat   highest word index to send (feat+1 words go out)
//   data   packed row, word i = data[i*LENGTH +: LENGTH]
//   ser    registered serial line, idles at 0
//   busy   high from the acceptance edge through the last stop bit
//   done   one-cycle pulse right after the last stop bit
module serial_out #(
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int CNT_BITS     = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [3:0]            feat,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (MAX_FEATURES < 1) ? 1 : $clog2(MAX_FEATURES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] frame_reg;
  logic [IDX_W-1:0]      feat_reg;
  logic [IDX_W-1:0]      word_cnt;
  logic [IDX_W-1:0]      next_idx;
  logic [LENGTH-1:0]     shift_reg;
  logic [CNT_BITS-1:0]   bit_cnt;

  // Requests beyond the row size are clamped so the word index can never run
  // past the latched row.
  function automatic logic [IDX_W-1:0] clamp_feat(input logic [3:0] f);
    int v;
    v = int'(f);
    if (v > MAX_FEATURES) v = MAX_FEATURES;
    return IDX_W'(v);
  endfunction

  function automatic logic [LENGTH-1:0] row_word(input logic [DATA_WIDTH-1:0] row,
                                                 input logic [IDX_W-1:0]      idx);
    return row[int'(idx)*LENGTH +: LENGTH];
  endfunction

  assign next_idx = word_cnt + IDX_W'(1);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      ser       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_reg <= '0;
      feat_reg  <= '0;
      word_cnt  <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ser  <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            // Only the latched copies are used from here on, so the caller
            // may change data/feat freely while the row is being sent.
            frame_reg <= data;
            feat_reg  <= clamp_feat(feat);
            word_cnt  <= '0;
            shift_reg <= data[LENGTH-1:0];
            ser       <= 1'b1;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          ser     <= shift_reg[LENGTH-1];
          bit_cnt <= CNT_BITS'(LENGTH - 1);
          state   <= S_DATA;
        end
        S_DATA: begin
          // MSB is already on the line when bit_cnt is loaded, so LENGTH-1
          // shifts plus the exit cycle give exactly LENGTH data cycles.
          if (bit_cnt != '0) begin
            shift_reg <= {shift_reg[LENGTH-2:0], 1'b0};
            ser       <= shift_reg[LENGTH-2];
            bit_cnt   <= bit_cnt - CNT_BITS'(1);
          end else begin
            ser   <= 1'b0;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (word_cnt == feat_reg) begin
            ser   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            // Next word's start bit follows the stop bit with no gap.
            word_cnt  <= next_idx;
            shift_reg <= row_word(frame_reg, next_idx);
            ser       <= 1'b1;
            state     <= S_START;
          end
        end
        S_DONE: begin
          ser   <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ser   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_out.sv
// Testbench for serial_out: table of transfers checked against a frame-level
// model of the line plus a receiver that reassembles words from the line.
module tb_serial_out;

  localparam int MAXF  = 15;
  localparam int LEN   = 16;
  localparam int DW    = LEN * (MAXF + 1);
  localparam int FRAME = LEN + 2;
  localparam int NVEC  = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [3:0]    feat;
  logic [DW-1:0] data;
  logic          ser;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  serial_out #(
    .MAX_FEATURES(MAXF),
    .LENGTH(LEN),
    .DATA_WIDTH(DW),
    .CNT_BITS(5)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .feat(feat),
    .data(data),
    .ser(ser),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [3:0]    feat;
    logic [DW-1:0] data;
    bit            disturb;
    int            exp_busy;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LEN-1:0] word_of(input logic [DW-1:0] d, input int i);
    return d[i*LEN +: LEN];
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Called at a negedge; asserts start immediately, samples every following
  // negedge through the DONE cycle and one idle cycle after it.
  task automatic run_transfer(input int id, input logic [3:0] f, input logic [DW-1:0] d,
                              input bit disturb, input int exp_busy);
    bit            exp_q[$];
    bit            obs[$];
    logic [LEN-1:0] w_exp;
    logic [LEN-1:0] w_got;
    int            total;
    int            nb = 0;
    int            nd = 0;
    int            done_at = -1;
    int            first_bad = -1;
    int            busy_bad = -1;

    // Line model: each word is 1, its bits MSB first, then 0.
    for (int w = 0; w <= int'(f); w++) begin
      w_exp = word_of(d, w);
      exp_q.push_back(1'b1);
      for (int b = LEN - 1; b >= 0; b--) exp_q.push_back(w_exp[b]);
      exp_q.push_back(1'b0);
    end
    total = exp_q.size();
    exp_q.push_back(1'b0);   // DONE cycle
    exp_q.push_back(1'b0);   // first idle cycle

    start = 1'b1;
    feat  = f;
    data  = d;
    for (int c = 0; c < total + 2; c++) begin
      @(negedge CLK);
      if (c == 0) start = 1'b0;
      obs.push_back(ser);
      if (ser !== exp_q[c] && first_bad < 0) first_bad = c;
      if (busy === 1'b1) nb++;
      if ((busy === 1'b1) != (c < total) && busy_bad < 0) busy_bad = c;
      if (done === 1'b1) begin
        nd++;
        done_at = c;
      end
      if (disturb) begin
        if (c == FRAME + 3) begin
          data = ~d;
          feat = ~f;
        end
        if (c == FRAME + 6 && f >= 4'd1) start = 1'b1;   // during DATA of word 1
        if (c == FRAME + 7) start = 1'b0;
        if (c == total) start = 1'b1;                    // during DONE
        if (c == total + 1) start = 1'b0;
      end
    end

    check($sformatf("v%0d_ser_first_bad_cycle", id), first_bad, -1);
    check($sformatf("v%0d_busy_cycles", id), nb, exp_busy);
    check($sformatf("v%0d_busy_window_bad_cycle", id), busy_bad, -1);
    check($sformatf("v%0d_done_pulses", id), nd, 1);
    check($sformatf("v%0d_done_cycle", id), done_at, total);

    // Receiver: reassemble words from the observed line.
    for (int w = 0; w <= int'(f); w++) begin
      w_got = '0;
      for (int b = 0; b < LEN; b++) w_got = {w_got[LEN-2:0], obs[w*FRAME + 1 + b]};
      check($sformatf("v%0d_rx_word%0d", id, w), w_got, word_of(d, w));
      check($sformatf("v%0d_rx_framing%0d", id, w),
            {obs[w*FRAME], obs[w*FRAME + FRAME - 1]}, 2'b10);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [3:0]    f;
    int            bad;

    // Vector table
    d = rand_row();
    d[LEN-1:0] = 16'hA5C3;
    vecs[0] = '{feat: 4'd0, data: d, disturb: 1'b0, exp_busy: 18};
    d = rand_row();
    d[0 +: LEN] = 16'h0001;
    d[LEN +: LEN] = 16'h8000;
    d[2*LEN +: LEN] = 16'hFFFF;
    vecs[1] = '{feat: 4'd2, data: d, disturb: 1'b0, exp_busy: 54};
    for (int i = 0; i <= MAXF; i++) d[i*LEN +: LEN] = 16'h1357 + 16'(i * 16'h0101);
    vecs[2] = '{feat: 4'd15, data: d, disturb: 1'b1, exp_busy: 288};
    vecs[3] = '{feat: 4'd1, data: rand_row(), disturb: 1'b1, exp_busy: 36};
    for (int i = 4; i < NVEC; i++) begin
      f = 4'($urandom_range(0, 3));
      vecs[i] = '{feat: f, data: rand_row(), disturb: 1'($urandom_range(0, 1)) & (f != 4'd0),
                  exp_busy: (int'(f) + 1) * FRAME};
    end

    // Reset held with start asserted: nothing may leave the block.
    RST   = 1'b0;
    start = 1'b1;
    feat  = 4'($urandom());
    data  = rand_row();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check($sformatf("reset_hold%0d_ser_busy_done", i), {ser, busy, done}, 3'b000);
    end
    start = 1'b0;
    RST   = 1'b1;
    @(negedge CLK);
    check("idle_after_reset", {ser, busy, done}, 3'b000);

    // Transfers back to back; each next start lands one cycle after DONE.
    for (int i = 0; i < NVEC; i++)
      run_transfer(i, vecs[i].feat, vecs[i].data, vecs[i].disturb, vecs[i].exp_busy);

    // Reset in the middle of word 0 at data bit 7.
    d = rand_row();
    start = 1'b1;
    feat  = 4'd0;
    data  = d;
    for (int c = 0; c <= 9; c++) begin
      @(negedge CLK);
      if (c == 0) start = 1'b0;
    end
    check("midreset_bit7_before", ser, d[7]);
    RST = 1'b0;
    @(negedge CLK);
    check("midreset_line_cleared", {ser, busy, done}, 3'b000);
    RST = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      if (ser !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("midreset_quiet_cycles_bad", bad, 0);

    run_transfer(100, 4'd0, rand_row(), 1'b0, 18);
    run_transfer(101, 4'd3, rand_row(), 1'b1, 72);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_out.md
Name: serial_out

Overview:
- Transmit-side counterpart of the serial loader. Takes a packed row of up to MAX_FEATURES+1 words, such as trained SGD weights plus bias or one RAM row, and shifts it out on a single serial line.
- Each word is framed with a start bit and a stop bit.
- Sits beside the top-level controller and is kicked off by a start strobe once training holds.
- Reports busy while running and pulses done on completion.

Parameters:
- MAX_FEATURES, 15, maximum feature count; the row holds MAX_FEATURES+1 words.
- LENGTH, 16, bits per word.
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1), width of the packed input row.
- CNT_BITS, 5, width of the bit counter; must satisfy 2^CNT_BITS > LENGTH.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-low reset (RST=0 at a rising CLK edge resets).
- start  input  1  request to transmit; sampled only in IDLE.
- feat  input  4  highest word index to send; words 0..feat are sent, i.e. feat+1 words.
- data  input  DATA_WIDTH  packed row; word i = data[i*LENGTH +: LENGTH].
- ser  output  1  serial line; registered; idle level 0.
- busy  output  1  high from the acceptance edge through the last stop bit.
- done  output  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (RST=0 at an edge): state=IDLE; ser=0, busy=0, done=0; counters and shift register cleared. Reset wins over every other event, including mid-frame; the line returns to 0 on that edge with no partial stop bit.
- States: IDLE, START_BIT, DATA, STOP_BIT, DONE.
- IDLE:
  - ser=0, busy=0.
  - On an edge with start=1: latch data into frame_reg and feat into feat_reg (clamped to MAX_FEATURES if larger); set word_cnt=0; load shift_reg with word 0; set ser=1, busy=1; go to START_BIT.
- START_BIT (1 cycle, ser=1): next edge sets ser=shift_reg[LENGTH-1], bit_cnt=LENGTH-1, goes to DATA.
- DATA:
  - Word is sent MSB first.
  - Each edge: if bit_cnt!=0, shift left, ser=next MSB, bit_cnt-1.
  - When bit_cnt==0: ser=0, go to STOP_BIT.
  - Exactly LENGTH cycles are spent in DATA.
- STOP_BIT (1 cycle, ser=0):
  - If word_cnt==feat_reg: go to DONE, busy=0, done=1.
  - Otherwise: word_cnt+1, load shift_reg with the next word, ser=1, go to START_BIT.
- DONE (1 cycle): done=1, ser=0; next edge done=0, state=IDLE. start is ignored in DONE and accepted from IDLE on the following cycle.
- Frame timing:
  - Per word: LENGTH+2 cycles (start, LENGTH data bits, stop).
  - Total busy cycles = (feat+1)*(LENGTH+2).
  - done asserts in the cycle immediately after the last stop bit.
- start while busy or in DONE: ignored, no restart, no queueing.
- data/feat changes while busy have no effect; only the latched copies are used.
- feat=0: a single word is sent.

Test Plan:
- RST=0 for 2 edges with start=1 and random data -> ser=0, busy=0, done=0 held; no frame is emitted while RST=0.
- feat=0, word0=16'hA5C3, start pulse -> ser sequence 1,1010010111000011,0 over 18 cycles; busy high exactly 18 cycles; done pulse on cycle 19; ser=0 afterwards.
- feat=2, words 16'h0001, 16'h8000, 16'hFFFF -> three 18-cycle frames back-to-back with no idle gap; busy 54 cycles; one done pulse; receiver model reconstructs all three words.
- feat=15, all 16 words distinct -> busy 288 cycles; words arrive in index order 0..15; data changed mid-frame has no effect on the output.
- start re-asserted during DATA of word 1 and during DONE -> no restart or extra frame; a start one cycle after DONE begins a new transfer.
- RST=0 asserted in the middle of DATA of word 0 (bit 7) -> next edge ser=0, busy=0, done never pulses; after RST=1 and a new start, a full correct frame is sent.
